// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed gaussian FIR.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Saturation works on a fixed wide container so any accumulator width fits.
  localparam int SAT_ACCW = 256;

  function automatic int acc_width(input int width, input int ncoefs);
    return 2 * width + $clog2(ncoefs);
  endfunction

  function automatic logic signed [SAT_ACCW-1:0] sat(input logic signed [SAT_ACCW-1:0] acc,
                                                     input int frac, input int width);
    logic signed [SAT_ACCW-1:0] sh, hi, lo;
    sh = acc >>> frac;
    hi = (SAT_ACCW'(1) <<< (width - 1)) - SAT_ACCW'(1);
    lo = -hi - SAT_ACCW'(1);
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate: one product per enabled cycle, clr restarts the sum.
// Registered result, no internal stall; the sequencer gates it with en.
module fir_mac #(
  parameter int WIDTH = 32,
  parameter int ACCW  = 68
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACCW-1:0]  acc
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: steps one MAC through NCOEFS taps per sample; yn_valid rises NCOEFS+1 edges after accept.
// xn_ready only in IDLE; the result is held in OUT until yn_ready, stalling further input.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NCOEFS = 10,
  parameter int FRAC   = 8
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic                      xn_valid,
  output logic                      xn_ready,
  input  logic signed [WIDTH-1:0]   xn,
  input  logic                      coef_we,
  input  logic [$clog2(NCOEFS)-1:0] coef_addr,
  input  logic signed [WIDTH-1:0]   coef_wdata,
  output logic                      coef_drop,
  output logic                      yn_valid,
  input  logic                      yn_ready,
  output logic signed [WIDTH-1:0]   yn,
  output logic                      busy
);

  localparam int AW   = $clog2(NCOEFS);
  localparam int ACCW = acc_width(WIDTH, NCOEFS);

  state_t                   state, state_nx;
  logic [AW-1:0]            k, wptr, xidx;
  logic signed [WIDTH-1:0]  xline [NCOEFS];
  logic signed [WIDTH-1:0]  coef  [NCOEFS];
  logic signed [ACCW-1:0]   acc;
  logic                     accept, last_tap, handshake, coef_ok;

  assign accept    = (state == IDLE) && xn_valid;
  assign last_tap  = (k == AW'(NCOEFS - 1));
  assign handshake = (state == OUT) && yn_valid && yn_ready;
  assign coef_ok   = (state == IDLE) && (int'(coef_addr) < NCOEFS);
  assign xn_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xn_valid)  state_nx = MAC;
      MAC:     if (last_tap)  state_nx = OUT;
      OUT:     if (handshake) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Newest sample sits at wptr; tap k reads k samples back, modulo the line depth.
  always_comb begin
    if (wptr >= k) xidx = wptr - k;
    else           xidx = AW'(int'(wptr) + NCOEFS - int'(k));
  end

  fir_mac #(.WIDTH(WIDTH), .ACCW(ACCW)) u_mac (
    .clock  (clock),
    .nreset (nreset),
    .clr    (accept),
    .en     (state == MAC),
    .a      (coef[k]),
    .b      (xline[xidx]),
    .acc    (acc)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      k    <= '0;
      wptr <= '0;
    end else begin
      if (accept)              k <= '0;
      else if (state == MAC)   k <= last_tap ? '0 : k + 1'b1;
      if (handshake)           wptr <= (wptr == AW'(NCOEFS - 1)) ? '0 : wptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NCOEFS; i++) xline[i] <= '0;
    end else if (accept) begin
      xline[wptr] <= xn;
    end
  end

  // Bank resets to a unity tap 0 so an unconfigured filter passes samples through.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NCOEFS; i++) coef[i] <= (i == 0) ? WIDTH'(1 << FRAC) : '0;
      coef_drop <= 1'b0;
    end else if (coef_we) begin
      if (coef_ok) coef[coef_addr] <= coef_wdata;
      else         coef_drop <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      yn       <= '0;
      yn_valid <= 1'b0;
    end else if ((state == OUT) && !yn_valid) begin
      yn       <= WIDTH'(sat(SAT_ACCW'(acc), FRAC, WIDTH));
      yn_valid <= 1'b1;
    end else if (handshake) begin
      yn_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: a reference FIR predicts each output at accept time.
module tb_fir_mac_sequencer;

  localparam int W = 32;
  localparam int N = 10;
  localparam int F = 8;

  logic          clock = 1'b0;
  logic          nreset;
  logic          xn_valid, xn_ready, coef_we, coef_drop, yn_valid, yn_ready, busy;
  logic [W-1:0]  xn, coef_wdata, yn;
  logic [3:0]    coef_addr;

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            accept_cyc = 0;
  logic          prev_v = 1'b0;
  logic [W-1:0]  exp_q [$];
  int            m_coef [N];
  longint        m_hist [N];

  fir_mac_sequencer #(.WIDTH(W), .NCOEFS(N), .FRAC(F)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .xn_valid   (xn_valid),
    .xn_ready   (xn_ready),
    .xn         (xn),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_drop  (coef_drop),
    .yn_valid   (yn_valid),
    .yn_ready   (yn_ready),
    .yn         (yn),
    .busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_coef[i] = (i == 0) ? 256 : 0;
      m_hist[i] = 0;
    end
  endtask

  function automatic logic [W-1:0] model_push(input logic [W-1:0] v);
    longint s = 0;
    for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = longint'($signed(v));
    for (int i = 0; i < N; i++) s += longint'(m_coef[i]) * m_hist[i];
    s = s >>> F;
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s[W-1:0];
  endfunction

  // Output monitor: latency on every rising yn_valid, data on every handshake.
  always @(negedge clock) begin
    if (nreset) begin
      if (yn_valid && !prev_v) chk_eq("latency", 64'(cyc - accept_cyc), 64'(N + 1));
      if (yn_valid && yn_ready) begin
        if (exp_q.size() == 0) chk_eq("unexpected_yn", yn, 64'hDEAD);
        else                   chk_eq("yn", yn, exp_q.pop_front());
      end
    end
    prev_v = yn_valid;
  end

  task automatic send(input logic [W-1:0] v);
    int t = 0;
    @(negedge clock);
    while (!xn_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!xn_ready) begin
      chk_eq("xn_ready_wait", xn_ready, 1);
      return;
    end
    xn = v;
    xn_valid = 1'b1;
    @(posedge clock);
    #1;
    accept_cyc = cyc;
    xn_valid = 1'b0;
    exp_q.push_back(model_push(v));
  endtask

  task automatic write_coef(input int addr, input logic [W-1:0] val, input bit applied);
    @(negedge clock);
    coef_addr = 4'(addr);
    coef_wdata = val;
    coef_we = 1'b1;
    @(posedge clock);
    #1;
    coef_we = 1'b0;
    if (applied) m_coef[addr] = int'($signed(val));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) chk_eq("drain", 64'(exp_q.size()), 0);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!yn_valid && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!yn_valid) chk_eq("yn_valid_wait", yn_valid, 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    nreset = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0;
    xn_valid = 1'b0;
    xn = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    yn_ready = 1'b1;
    model_reset();
    #12;
    chk_eq("rst_yn_valid", yn_valid, 0);
    chk_eq("rst_yn", yn, 0);
    chk_eq("rst_coef_drop", coef_drop, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_xn_ready", xn_ready, 1);
    @(negedge clock);
    nreset = 1'b1;

    // Passthrough from reset coefficients
    send(32'd5);
    drain();

    // Out-of-range tap index is discarded
    write_coef(12, 32'h500, 1'b0);
    @(negedge clock);
    chk_eq("drop_addr", coef_drop, 1);
    send(32'd6);
    drain();
    do_reset();
    chk_eq("drop_cleared", coef_drop, 0);

    // Write while busy is discarded and sticky
    send(32'd9);
    write_coef(0, 32'h300, 1'b0);
    @(negedge clock);
    chk_eq("drop_busy", coef_drop, 1);
    drain();
    send(32'd4);
    drain();
    chk_eq("drop_sticky", coef_drop, 1);

    // Impulse response walks the coefficient bank
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, 32'((i + 1) << 8), 1'b1);
    send(32'd256);
    repeat (N) send(32'd0);
    drain();

    // Saturation at both rails
    do_reset();
    write_coef(0, 32'h200, 1'b1);
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    drain();

    // Backpressure holds the result in OUT
    do_reset();
    yn_ready = 1'b0;
    send(32'd21);
    wait_valid();
    repeat (5) begin
      @(negedge clock);
      chk_eq("bp_yn", yn, (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'hBAD);
      chk_eq("bp_valid", yn_valid, 1);
      chk_eq("bp_xn_ready", xn_ready, 0);
    end
    @(posedge clock);
    #1;
    yn_ready = 1'b1;
    drain();
    @(negedge clock);
    chk_eq("bp_idle_ready", xn_ready, 1);
    chk_eq("bp_idle_busy", busy, 0);

    // Reset while a result is waiting drops yn_valid without a clock edge
    yn_ready = 1'b0;
    send(32'd11);
    wait_valid();
    #2;
    nreset = 1'b0;
    #1;
    chk_eq("rst_out_valid", yn_valid, 0);
    chk_eq("rst_out_yn", yn, 0);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
    yn_ready = 1'b1;

    // Moving sum across several write-pointer wraps
    do_reset();
    for (int i = 0; i < N; i++) write_coef(i, 32'h100, 1'b1);
    repeat (25) send(32'd3);
    drain();

    // Reset mid-MAC loses the sample and restores passthrough
    send(32'd3);
    repeat (3) @(negedge clock);
    chk_eq("mid_mac_busy", busy, 1);
    #2;
    nreset = 1'b0;
    #1;
    chk_eq("mid_rst_valid", yn_valid, 0);
    chk_eq("mid_rst_busy", busy, 0);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    nreset = 1'b1;
    send(32'd7);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
